// File: rtl/ym3438_pkg.sv
// Shared definitions for the YM3438 slot-counter slice: head-slot mode encodings
// and an elaboration-time ceiling-log2 helper.
package ym3438_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_ADD   = 2'd1,
        MODE_LOAD  = 2'd2,
        MODE_CLEAR = 2'd3
    } mode_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ym3438_slot_ring.sv
// Two-phase master/slave delay ring: c1 shifts slaves into the next masters
// (din enters stage 0), c2 copies every master into its slave.
module ym3438_slot_ring #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned SLOTS = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             c1_i,
    input  logic             c2_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o
);

    logic [SLOTS-1:0][WIDTH-1:0] master_q, master_d;
    logic [SLOTS-1:0][WIDTH-1:0] slave_q, slave_d;

    // Both phases read only the old registers, so c1 and c2 on one edge never flow through.
    always_comb begin
        master_d = master_q;
        slave_d  = slave_q;
        if (c1_i) master_d = {slave_q[SLOTS-2:0], din_i};
        if (c2_i) slave_d = master_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            master_q <= '0;
            slave_q  <= '0;
        end else begin
            master_q <= master_d;
            slave_q  <= slave_d;
        end
    end

    assign head_o = slave_q[SLOTS-1];

endmodule

// File: rtl/ym3438_slot_counter.sv
// Time-multiplexed per-slot counter: a two-phase ring of SLOTS values whose head
// slot is held, incremented, loaded or cleared each c1 phase.
module ym3438_slot_counter
    import ym3438_pkg::*;
#(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned SLOTS    = 24,
    parameter int unsigned STEP_W   = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic                      MCLK,
    input  logic                      reset,
    input  logic                      c1,
    input  logic                      c2,
    input  logic [1:0]                mode,
    input  logic [STEP_W-1:0]         step,
    input  logic [WIDTH-1:0]          load_val,
    output logic [WIDTH-1:0]          val,
    output logic                      c_out,
    output logic [clog2(SLOTS)-1:0]   slot,
    output logic                      sync
);

    localparam int unsigned SLOT_W = clog2(SLOTS);

    logic [WIDTH-1:0]  head;
    logic [WIDTH-1:0]  next_val;
    logic [WIDTH:0]    sum;
    logic              add_carry;
    logic [SLOT_W-1:0] slot_q, slot_d;

    ym3438_slot_ring #(
        .WIDTH (WIDTH),
        .SLOTS (SLOTS)
    ) u_ring (
        .clk_i  (MCLK),
        .rst_i  (reset),
        .c1_i   (c1),
        .c2_i   (c2),
        .din_i  (next_val),
        .head_o (head)
    );

    always_comb begin
        sum       = {1'b0, head} + {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        next_val  = head;
        add_carry = 1'b0;
        case (mode_e'(mode))
            MODE_HOLD:  next_val = head;
            MODE_ADD: begin
                add_carry = sum[WIDTH];
                if (SATURATE != 0 && sum[WIDTH]) next_val = '1;
                else                             next_val = sum[WIDTH-1:0];
            end
            MODE_LOAD:  next_val = load_val;
            MODE_CLEAR: next_val = '0;
            default:    next_val = head;
        endcase
    end

    always_comb begin
        slot_d = slot_q;
        if (c2) slot_d = (slot_q == SLOT_W'(SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end

    always_ff @(posedge MCLK) begin
        if (reset) slot_q <= '0;
        else       slot_q <= slot_d;
    end

    // Reset is synchronous, so outputs are masked to hide pre-edge state while it is held.
    assign val   = reset ? '0 : head;
    assign c_out = !reset && add_carry;
    assign slot  = reset ? '0 : slot_q;
    assign sync  = (slot == '0);

endmodule

// File: tb/tb_ym3438_slot_counter.sv
// Bench for ym3438_slot_counter: wrapping and saturating instances share stimulus
// and are checked against a per-slot memory model indexed by the slot number.
module tb_ym3438_slot_counter;

    localparam int W  = 4;
    localparam int N  = 6;
    localparam int SW = 2;
    localparam int MAXV = (1 << W) - 1;
    localparam logic [1:0] HOLD = 2'd0, ADD = 2'd1, LOAD = 2'd2, CLR = 2'd3;

    logic          MCLK = 1'b0;
    logic          reset, c1, c2;
    logic [1:0]    mode;
    logic [SW-1:0] step;
    logic [W-1:0]  load_val;
    logic [W-1:0]  val_w, val_s;
    logic          cout_w, cout_s, sync_w, sync_s;
    logic [2:0]    slot_w, slot_s;

    int n_chk = 0;
    int n_err = 0;
    int mem_w[N];
    int mem_s[N];
    int mslot;
    int pend_w, pend_s;

    always #5 MCLK = ~MCLK;

    ym3438_slot_counter #(.WIDTH(W), .SLOTS(N), .STEP_W(SW), .SATURATE(0)) u_wrap (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .mode(mode), .step(step),
        .load_val(load_val), .val(val_w), .c_out(cout_w), .slot(slot_w), .sync(sync_w)
    );

    ym3438_slot_counter #(.WIDTH(W), .SLOTS(N), .STEP_W(SW), .SATURATE(1)) u_sat (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .mode(mode), .step(step),
        .load_val(load_val), .val(val_s), .c_out(cout_s), .slot(slot_s), .sync(sync_s)
    );

    function automatic int next_of(input int head, input int md, input int stp,
                                   input int ld, input bit sat);
        int s;
        case (md)
            0: return head;
            1: begin
                s = head + stp;
                if (s > MAXV) return sat ? MAXV : s - (MAXV + 1);
                return s;
            end
            2: return ld;
            default: return 0;
        endcase
    endfunction

    function automatic int carry_of(input int head, input int md, input int stp);
        return (md == 1 && head + stp > MAXV) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".val_w"},  32'(val_w),  mem_w[mslot]);
        chk({tag, ".val_s"},  32'(val_s),  mem_s[mslot]);
        chk({tag, ".slot_w"}, 32'(slot_w), mslot);
        chk({tag, ".slot_s"}, 32'(slot_s), mslot);
        chk({tag, ".sync_w"}, 32'(sync_w), (mslot == 0) ? 1 : 0);
        chk({tag, ".sync_s"}, 32'(sync_s), (mslot == 0) ? 1 : 0);
        chk({tag, ".cout_w"}, 32'(cout_w), carry_of(mem_w[mslot], int'(mode), int'(step)));
        chk({tag, ".cout_s"}, 32'(cout_s), carry_of(mem_s[mslot], int'(mode), int'(step)));
    endtask

    task automatic edge_step(input bit a, input bit b, input string tag);
        reset = 1'b0;
        c1 = a;
        c2 = b;
        #1;
        check_outputs(tag);
        if (a) begin
            pend_w = next_of(mem_w[mslot], int'(mode), int'(step), int'(load_val), 1'b0);
            pend_s = next_of(mem_s[mslot], int'(mode), int'(step), int'(load_val), 1'b1);
        end
        @(posedge MCLK);
        if (b) begin
            mem_w[mslot] = pend_w;
            mem_s[mslot] = pend_s;
            mslot = (mslot + 1) % N;
        end
        #1;
        c1 = 1'b0;
        c2 = 1'b0;
    endtask

    task automatic pair(input string tag);
        edge_step(1'b1, 1'b0, {tag, ".c1"});
        edge_step(1'b0, 1'b1, {tag, ".c2"});
    endtask

    task automatic hold_pairs(input int n);
        mode = HOLD;
        for (int i = 0; i < n; i++) pair("hold");
    endtask

    task automatic do_reset(input bit with_c1);
        reset = 1'b1;
        c1 = with_c1;
        c2 = 1'($urandom_range(0, 1));
        mode = ADD;
        step = 2'd3;
        #1;
        chk("rst.val_w",  32'(val_w),  0);
        chk("rst.val_s",  32'(val_s),  0);
        chk("rst.slot_w", 32'(slot_w), 0);
        chk("rst.sync_w", 32'(sync_w), 1);
        chk("rst.sync_s", 32'(sync_s), 1);
        chk("rst.cout_w", 32'(cout_w), 0);
        chk("rst.cout_s", 32'(cout_s), 0);
        @(posedge MCLK);
        for (int i = 0; i < N; i++) begin
            mem_w[i] = 0;
            mem_s[i] = 0;
        end
        mslot = 0;
        pend_w = 0;
        pend_s = 0;
        #1;
        reset = 1'b0;
        c1 = 1'b0;
        c2 = 1'b0;
        mode = HOLD;
        #1;
        check_outputs("post_rst");
    endtask

    initial begin
        int p, e_w, e_s;
        reset = 1'b1; c1 = 1'b0; c2 = 1'b0; mode = HOLD; step = '0; load_val = '0;
        mslot = 0; pend_w = 0; pend_s = 0;

        do_reset(1'b0);

        // refill: LOAD 1..6, then read back around the ring
        for (int i = 0; i < N; i++) begin
            mode = LOAD;
            load_val = W'(i + 1);
            pair("refill_ld");
        end
        mode = HOLD;
        for (int i = 0; i < N; i++) begin
            #1;
            chk("refill.val",  32'(val_w),  i + 1);
            chk("refill.slot", 32'(slot_w), i);
            chk("refill.sync", 32'(sync_w), (i == 0) ? 1 : 0);
            pair("refill_rd");
        end

        // simultaneous c1/c2 edge
        p = mslot;
        e_w = mem_w[(p + 1) % N];
        e_s = mem_s[(p + 1) % N];
        mode = LOAD;
        load_val = 4'd9;
        edge_step(1'b1, 1'b0, "sim.c1");
        c1 = 1'b1;
        c2 = 1'b1;
        @(posedge MCLK);
        #1;
        c1 = 1'b0;
        c2 = 1'b0;
        chk("sim.val_w",  32'(val_w),  e_w);
        chk("sim.val_s",  32'(val_s),  e_s);
        chk("sim.slot_w", 32'(slot_w), (p + 1) % N);
        c2 = 1'b1;
        @(posedge MCLK);
        #1;
        c2 = 1'b0;
        chk("sim_noflow.val_w",  32'(val_w),  e_w);
        chk("sim_noflow.slot_w", 32'(slot_w), (p + 2) % N);
        do_reset(1'b0);

        // ADD wrap / saturate: head 15 + 1
        mode = LOAD; load_val = 4'd15; pair("w15");
        hold_pairs(N - 1);
        mode = ADD; step = 2'd1; #1;
        chk("wrap.cout_w", 32'(cout_w), 1);
        chk("wrap.cout_s", 32'(cout_s), 1);
        pair("wrap_add");
        hold_pairs(N - 1);
        #1;
        chk("wrap.val_w", 32'(val_w), 0);
        chk("wrap.val_s", 32'(val_s), 15);

        // ADD saturate: head 14 + 3, then again
        mode = LOAD; load_val = 4'd14; pair("w14");
        hold_pairs(N - 1);
        mode = ADD; step = 2'd3; #1;
        chk("sat1.cout_w", 32'(cout_w), 1);
        chk("sat1.cout_s", 32'(cout_s), 1);
        pair("sat1_add");
        hold_pairs(N - 1);
        #1;
        chk("sat1.val_w", 32'(val_w), 1);
        chk("sat1.val_s", 32'(val_s), 15);
        mode = ADD; step = 2'd3; #1;
        chk("sat2.cout_w", 32'(cout_w), 0);
        chk("sat2.cout_s", 32'(cout_s), 1);
        pair("sat2_add");
        hold_pairs(N - 1);
        #1;
        chk("sat2.val_w", 32'(val_w), 4);
        chk("sat2.val_s", 32'(val_s), 15);

        // idle edges inside and between phase pairs
        mode = LOAD; load_val = 4'd7;
        edge_step(1'b1, 1'b0, "idle.c1");
        for (int i = 0; i < 3; i++) edge_step(1'b0, 1'b0, "idle.mid");
        edge_step(1'b0, 1'b1, "idle.c2");
        for (int i = 0; i < 3; i++) edge_step(1'b0, 1'b0, "idle.gap");
        hold_pairs(N - 1);
        #1;
        chk("idle.val_w", 32'(val_w), 7);
        chk("idle.val_s", 32'(val_s), 7);

        // reset mid-ring with c1 high
        mode = LOAD; load_val = 4'd5; pair("pre_rst");
        mode = LOAD; load_val = 4'd11;
        edge_step(1'b1, 1'b0, "pre_rst.c1");
        do_reset(1'b1);
        for (int i = 0; i < N; i++) begin
            #1;
            chk("midrst.val_w", 32'(val_w),  0);
            chk("midrst.val_s", 32'(val_s),  0);
            chk("midrst.slot",  32'(slot_w), i);
            pair("midrst");
        end

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
            mode = 2'($urandom_range(0, 3));
            step = SW'($urandom);
            load_val = W'($urandom);
            if ($urandom_range(0, 3) == 0) edge_step(1'b0, 1'b0, "rnd.idle0");
            edge_step(1'b1, 1'b0, "rnd.c1");
            if ($urandom_range(0, 3) == 0) edge_step(1'b0, 1'b0, "rnd.idle1");
            edge_step(1'b0, 1'b1, "rnd.c2");
        end
        #1;
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
